// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch controller.
// Holds FSM states, BHT counter encodings and RISC-V branch funct3 codes.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] BHT_RESET = CNT_WNT;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] c,
                                              input logic taken);
        logic [1:0] r;
        r = c;
        if (taken && c != CNT_ST) r = c + 2'd1;
        if (!taken && c != CNT_SNT) r = c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/branch_ctrl_bht.sv
// Branch history table of 2-bit saturating counters.
// One combinational read port and one synchronous update port.
module branch_ctrl_bht
    import branch_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] upd_cnt_d;

    // Reads see the pre-update value; no write-to-read bypass.
    assign rd_cnt = cnt_q[rd_idx];

    always_comb begin
        upd_cnt_d = sat_update(cnt_q[upd_idx], upd_taken);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= upd_cnt_d;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch sequencer: drives the comparator, checks the prediction,
// issues redirect and flush, and owns the direction predictor.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W    = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_jump,
    input  logic        ex_is_jalr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic        ex_pred_taken,
    output logic        br_en,
    output logic [2:0]  br_funct3,
    output logic [31:0] br_data_a,
    output logic [31:0] br_data_b,
    input  logic        br_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_misp_cnt
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [2:0]  f3_q, f3_d;
    logic        jump_q, jump_d;
    logic        jalr_q, jalr_d;
    logic        pred_q, pred_d;
    logic [31:0] rpc_q, rpc_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [31:0] pbr_q, pbr_d;
    logic [31:0] pmisp_q, pmisp_d;

    logic [1:0]  rd_cnt;
    logic        upd_en;
    logic        actual;
    logic        misp;
    logic        legal;
    logic        unused_pc;

    assign unused_pc = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

    branch_ctrl_bht #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[BHT_IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .upd_en   (upd_en),
        .upd_idx  (pc_q[BHT_IDX_W+1:2]),
        .upd_taken(actual)
    );

    assign if_pred_taken  = rd_cnt[1];
    assign ex_ready       = (state_q == ST_IDLE);
    assign br_en          = (state_q == ST_EVAL) && !jump_q;
    assign br_funct3      = f3_q;
    assign br_data_a      = rs1_q;
    assign br_data_b      = rs2_q;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign flush          = (state_q == ST_REDIRECT) ||
                            (state_q == ST_FLUSH);
    assign redirect_pc    = rpc_q;
    assign perf_br_cnt    = pbr_q;
    assign perf_misp_cnt  = pmisp_q;

    // Illegal funct3 resolves not-taken regardless of the comparator.
    assign legal  = f3_legal(f3_q);
    assign actual = jump_q ? 1'b1 : (br_taken && legal);
    assign misp   = jump_q || (actual != pred_q);
    assign upd_en = (state_q == ST_EVAL) && !jump_q && legal;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        jump_d  = jump_q;
        jalr_d  = jalr_q;
        pred_d  = pred_q;
        rpc_d   = rpc_q;
        fcnt_d  = fcnt_q;
        pbr_d   = pbr_q;
        pmisp_d = pmisp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    pc_d    = ex_pc;
                    imm_d   = ex_imm;
                    rs1_d   = ex_rs1;
                    rs2_d   = ex_rs2;
                    f3_d    = ex_funct3;
                    jump_d  = ex_is_jump;
                    jalr_d  = ex_is_jalr;
                    pred_d  = ex_pred_taken;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (jalr_q && jump_q) begin
                    rpc_d = (rs1_q + imm_q) & ~32'd1;
                end else if (actual) begin
                    rpc_d = pc_q + imm_q;
                end else begin
                    rpc_d = pc_q + 32'd4;
                end
                if (!jump_q) begin
                    pbr_d = pbr_q + 32'd1;
                    if (actual != pred_q) pmisp_d = pmisp_q + 32'd1;
                end
                state_d = misp ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                if (FLUSH_CYCLES <= 1) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = 8'(FLUSH_CYCLES - 2);
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            jump_q  <= 1'b0;
            jalr_q  <= 1'b0;
            pred_q  <= 1'b0;
            rpc_q   <= '0;
            fcnt_q  <= '0;
            pbr_q   <= '0;
            pmisp_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            jump_q  <= jump_d;
            jalr_q  <= jalr_d;
            pred_q  <= pred_d;
            rpc_q   <= rpc_d;
            fcnt_q  <= fcnt_d;
            pbr_q   <= pbr_d;
            pmisp_q <= pmisp_d;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed vector bench for branch_ctrl with an external comparator model.
// Tracks expected BHT counters and perf counts alongside the DUT.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_jump;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        ex_pred_taken;
    logic        br_en;
    logic [2:0]  br_funct3;
    logic [31:0] br_data_a;
    logic [31:0] br_data_b;
    logic        br_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_misp_cnt;

    int errors = 0;
    int checks = 0;

    logic [1:0] bht_m [64];
    int         exp_br;
    int         exp_misp;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        jump;
        logic        jalr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
        logic        tk;
        logic        upd;
        logic        redir;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs [10];

    branch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_is_jump    (ex_is_jump),
        .ex_is_jalr    (ex_is_jalr),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_pred_taken (ex_pred_taken),
        .br_en         (br_en),
        .br_funct3     (br_funct3),
        .br_data_a     (br_data_a),
        .br_data_b     (br_data_b),
        .br_taken      (br_taken),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .perf_br_cnt   (perf_br_cnt),
        .perf_misp_cnt (perf_misp_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        br_taken = 1'b0;
        if (br_en) begin
            case (br_funct3)
                3'b000: br_taken = (br_data_a == br_data_b);
                3'b001: br_taken = (br_data_a != br_data_b);
                3'b100: br_taken = ($signed(br_data_a) < $signed(br_data_b));
                3'b101: br_taken = ($signed(br_data_a) >= $signed(br_data_b));
                3'b110: br_taken = (br_data_a < br_data_b);
                3'b111: br_taken = (br_data_a >= br_data_b);
                default: br_taken = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
        exp_br   = 0;
        exp_misp = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int         idx;
        logic [1:0] old;
        idx = int'(v.pc[7:2]);
        old = bht_m[idx];
        if_pc         = v.pc;
        ex_valid      = 1'b1;
        ex_is_jump    = v.jump;
        ex_is_jalr    = v.jalr;
        ex_funct3     = v.f3;
        ex_pc         = v.pc;
        ex_imm        = v.imm;
        ex_rs1        = v.rs1;
        ex_rs2        = v.rs2;
        ex_pred_taken = v.pred;
        #1;
        chk({v.name, " ready"}, 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        chk({v.name, " br_en"}, 32'(br_en), 32'(!v.jump));
        chk({v.name, " bht_old"}, 32'(if_pred_taken), 32'(old[1]));
        if (v.upd) bht_m[idx] = sat(old, v.tk);
        if (!v.jump) begin
            exp_br++;
            if (v.tk != v.pred) exp_misp++;
        end
        tick();
        chk({v.name, " bht_new"}, 32'(if_pred_taken), 32'(bht_m[idx][1]));
        chk({v.name, " redir"}, 32'(redirect_valid), 32'(v.redir));
        chk({v.name, " perf_br"}, perf_br_cnt, 32'(exp_br));
        chk({v.name, " perf_misp"}, perf_misp_cnt, 32'(exp_misp));
        if (v.redir) begin
            chk({v.name, " rpc"}, redirect_pc, v.rpc);
            chk({v.name, " flush0"}, 32'(flush), 32'd1);
            chk({v.name, " ready0"}, 32'(ex_ready), 32'd0);
            tick();
            chk({v.name, " redir1"}, 32'(redirect_valid), 32'd0);
            chk({v.name, " flush1"}, 32'(flush), 32'd1);
            tick();
            chk({v.name, " flush2"}, 32'(flush), 32'd0);
        end else begin
            chk({v.name, " noflush"}, 32'(flush), 32'd0);
        end
        chk({v.name, " ready_end"}, 32'(ex_ready), 32'd1);
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] f3,
                                input logic j, input logic jr,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic pr, input logic tk,
                                input logic up, input logic rd,
                                input logic [31:0] rpc);
        vec_t v;
        v.name = nm; v.f3 = f3; v.jump = j; v.jalr = jr;
        v.pc = pc; v.imm = imm; v.rs1 = a; v.rs2 = b;
        v.pred = pr; v.tk = tk; v.upd = up; v.redir = rd; v.rpc = rpc;
        return v;
    endfunction

    initial begin
        vecs[0] = mk("beq_tk", 3'b000, 0, 0, 32'h100, 32'h20, 5, 5,
                     0, 1, 1, 1, 32'h120);
        vecs[1] = mk("bne_nt", 3'b001, 0, 0, 32'h204, 32'h20, 7, 7,
                     0, 0, 1, 0, 32'h0);
        vecs[2] = mk("blt_neg", 3'b100, 0, 0, 32'h308, 32'h40,
                     32'hFFFFFFFF, 1, 1, 1, 1, 0, 32'h0);
        vecs[3] = mk("bltu_big", 3'b110, 0, 0, 32'h30C, 32'h40,
                     32'hFFFFFFFF, 1, 1, 0, 1, 1, 32'h310);
        vecs[4] = mk("jal_wrap", 3'b000, 1, 0, 32'hFFFFFFF0, 32'h20, 0, 0,
                     0, 1, 0, 1, 32'h10);
        vecs[5] = mk("ill_f3", 3'b010, 0, 0, 32'h410, 32'h40, 9, 9,
                     1, 0, 0, 1, 32'h414);
        vecs[6] = mk("bge_eq", 3'b101, 0, 0, 32'h414, 32'h40, 3, 3,
                     1, 1, 1, 0, 32'h0);
        vecs[7] = mk("blt_back", 3'b100, 0, 0, 32'h500, 32'hFFFFFFF0, 1, 2,
                     0, 1, 1, 1, 32'h4F0);
        vecs[8] = mk("bgeu_nt", 3'b111, 0, 0, 32'h518, 32'h8, 1, 2,
                     0, 0, 1, 0, 32'h0);
        vecs[9] = mk("bne_tk", 3'b001, 0, 0, 32'h51C, 32'h100, 1, 2,
                     1, 1, 1, 0, 32'h0);

        rst = 1'b1; if_pc = 0; ex_valid = 0; ex_is_jump = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_pred_taken = 0;
        model_reset();
        #12;
        chk("rst ready", 32'(ex_ready), 32'd1);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst redir", 32'(redirect_valid), 32'd0);
        chk("rst br_en", 32'(br_en), 32'd0);
        chk("rst rpc", redirect_pc, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // JALR with a new request held while flushing
        run_vec(mk("jalr", 3'b000, 1, 1, 32'h400, 32'h2, 32'h1001, 0,
                   0, 1, 0, 1, 32'h1002));
        begin
            vec_t j;
            j = mk("jalr2", 3'b000, 1, 1, 32'h400, 32'h2, 32'h1001, 0,
                   0, 1, 0, 1, 32'h1002);
            ex_valid = 1'b1; ex_is_jump = 1; ex_is_jalr = 1;
            ex_pc = j.pc; ex_imm = j.imm; ex_rs1 = j.rs1;
            tick();
            tick();
            chk("stall redir", 32'(redirect_valid), 32'd1);
            ex_is_jump = 0; ex_is_jalr = 0; ex_funct3 = 3'b000;
            ex_rs1 = 1; ex_rs2 = 1;
            tick();
            chk("stall ready", 32'(ex_ready), 32'd0);
            ex_valid = 1'b0;
            tick();
            chk("stall idle", 32'(ex_ready), 32'd1);
            tick();
            chk("stall ignored", 32'(br_en), 32'd0);
            chk("stall perf", perf_br_cnt, 32'(exp_br));
        end

        // Saturation at one index; read during update returns old value
        for (int k = 0; k < 4; k++) begin
            run_vec(mk("bgeu_sat", 3'b111, 0, 0, 32'h620, 32'h10, 4, 4,
                       1, 1, 1, 0, 32'h0));
        end
        chk("sat state", 32'(bht_m[8]), 32'd3);
        if_pc = 32'h620; #1;
        chk("sat pred", 32'(if_pred_taken), 32'd1);

        // Reset in the middle of a flush
        ex_valid = 1'b1; ex_is_jump = 1; ex_is_jalr = 0;
        ex_pc = 32'h700; ex_imm = 32'h40;
        tick();
        ex_valid = 1'b0;
        tick();
        tick();
        chk("pre-rst flush", 32'(flush), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid-rst flush", 32'(flush), 32'd0);
        chk("mid-rst ready", 32'(ex_ready), 32'd1);
        chk("mid-rst perf_br", perf_br_cnt, 32'd0);
        chk("mid-rst perf_misp", perf_misp_cnt, 32'd0);
        model_reset();
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                if_pc = 32'(i * 4); #1;
                if (if_pred_taken !== 1'b0) bad++;
            end
            chk("rst bht msb", 32'(bad), 32'd0);
        end
        tick();
        rst = 1'b0;
        tick();
        run_vec(mk("post_rst", 3'b000, 0, 0, 32'h620, 32'h8, 1, 1,
                   0, 1, 1, 1, 32'h628));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
